// File: rtl/lpc_cycle_fifo_pkg.sv
// ============================================================================
// lpc_cycle_fifo_pkg : LPC cycle-record field layout and FIFO control states
// Revision 1.0
// ============================================================================
`default_nettype none

package lpc_cycle_fifo_pkg;

  // Cycle-type codes carried in tdata[1:0]
  localparam logic [1:0] LPC_CYC_NONE = 2'b00;
  localparam logic [1:0] LPC_CYC_WR   = 2'b01;
  localparam logic [1:0] LPC_CYC_RD   = 2'b11;

  // Cycle-record field bounds
  localparam int TD_ADDR_HI = 27;
  localparam int TD_ADDR_LO = 12;
  localparam int TD_DATA_HI = 11;
  localparam int TD_DATA_LO = 4;
  localparam int TD_TYPE_HI = 1;
  localparam int TD_TYPE_LO = 0;

  // FIFO control state encoding
  localparam int         FIFO_ST_W    = 2;
  localparam logic [1:0] FIFO_EMPTY   = 2'd0;
  localparam logic [1:0] FIFO_PARTIAL = 2'd1;
  localparam logic [1:0] FIFO_FULL    = 2'd2;

  function automatic logic rec_is_none(input logic [31:0] rec);
    return rec[TD_TYPE_HI:TD_TYPE_LO] == LPC_CYC_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lpc_fifo_ram.sv
// ============================================================================
// lpc_fifo_ram : DEPTH x WIDTH storage, synchronous write, asynchronous read
// Revision 1.0
// ============================================================================
`default_nettype none

module lpc_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

`default_nettype wire

// File: rtl/lpc_cycle_fifo.sv
// ============================================================================
// lpc_cycle_fifo : edge-triggered LPC cycle-record FIFO with overflow counting
// Revision 1.0
// ============================================================================
`default_nettype none

module lpc_cycle_fifo
  import lpc_cycle_fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FILTER_NONE = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              tdata_i,
  input  logic                     ready_i,
  output logic [31:0]              m_tdata_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o,
  input  logic                     clear_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                 ready_q,    ready_d;
  logic [PW-1:0]        wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]        count_q,    count_d;
  logic [FIFO_ST_W-1:0] state_q,    state_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push_req;
  logic        pop;
  logic        wr_en;
  logic        drop;
  logic [31:0] rd_data;

  lpc_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (tdata_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ready_q    <= ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // A type-none record is ignored before it can consume a slot or count as a drop
  always_comb begin
    ready_d  = ready_i;
    push_req = ready_i & ~ready_q & ~((FILTER_NONE != 0) & rec_is_none(tdata_i));
    pop      = ~fifo_empty & m_tready_i;
    wr_en    = push_req & (~fifo_full | pop);
    drop     = push_req & fifo_full & ~pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_i) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (clear_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FIFO_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    if (count_d == '0) begin
      state_d = FIFO_EMPTY;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = FIFO_FULL;
    end else begin
      state_d = FIFO_PARTIAL;
    end
  end

  always_comb begin
    fifo_empty = (state_q == FIFO_EMPTY);
    fifo_full  = (state_q == FIFO_FULL);
  end

  assign m_tvalid_o = ~fifo_empty;
  assign m_tdata_o  = fifo_empty ? 32'd0 : rd_data;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lpc_cycle_fifo.sv
// ============================================================================
// tb_lpc_cycle_fifo : directed stimulus with queue scoreboard on popped records
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lpc_cycle_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   tdata = '0;
  logic          ready = 1'b0;
  logic          m_tready = 1'b0;
  logic          clear = 1'b0;

  logic [31:0]   m_tdata,    nf_tdata;
  logic          m_tvalid,   nf_tvalid;
  logic [CW-1:0] count,      nf_count;
  logic          overflow,   nf_overflow;
  logic [15:0]   drop_cnt,   nf_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  lpc_cycle_fifo #(.DEPTH(DEPTH), .FILTER_NONE(1)) dut (
    .clk_i(clk), .rst_i(rst), .tdata_i(tdata), .ready_i(ready),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .count_o(count), .overflow_o(overflow), .drop_cnt_o(drop_cnt), .clear_i(clear)
  );

  lpc_cycle_fifo #(.DEPTH(DEPTH), .FILTER_NONE(0)) dut_nf (
    .clk_i(clk), .rst_i(rst), .tdata_i(tdata), .ready_i(ready),
    .m_tdata_o(nf_tdata), .m_tvalid_o(nf_tvalid), .m_tready_i(m_tready),
    .count_o(nf_count), .overflow_o(nf_overflow), .drop_cnt_o(nf_drop_cnt), .clear_i(clear)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted head is compared with the oldest expected record
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", m_tdata, 32'hDEADDEAD);
      end else begin
        check("pop_data", m_tdata, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] mk_rec(input int i);
    return {4'h0, 16'h1000 + 16'(i), 8'(i * 3 + 1), 2'b00, 2'b01};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ready = 1'b0; m_tready = 1'b0; clear = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] rec, input int hold);
    tdata = rec; ready = 1'b1;
    repeat (hold) @(posedge clk);
    #1 ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    m_tready = 1'b1;
    while (count != 0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    m_tready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    check("empty_tdata", m_tdata, 32'd0);
    check("empty_tvalid", 32'(m_tvalid), 32'd0);
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      push(mk_rec(i), 1);
      exp_q.push_back(mk_rec(i));
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;

    // Single write record, ready held two cycles gives one entry
    @(posedge clk); #1;
    push(32'h00FE4A51, 2);
    exp_q.push_back(32'h00FE4A51);
    check("single_count", 32'(count), 32'd1);
    check("single_tdata", m_tdata, 32'h00FE4A51);
    check("single_tvalid", 32'(m_tvalid), 32'd1);
    drain();

    // Type-none filtering
    do_reset();
    push(32'h00123450, 1);
    check("filter_count", 32'(count), 32'd0);
    check("filter_drop", 32'(drop_cnt), 32'd0);
    check("nofilter_count", 32'(nf_count), 32'd1);
    check("nofilter_tdata", nf_tdata, 32'h00123450);

    // Fill plus two overflow pushes
    do_reset();
    fill16();
    push(mk_rec(16), 1);
    push(mk_rec(17), 1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_drop", 32'(drop_cnt), 32'd2);
    check("fill_overflow", 32'(overflow), 32'd1);

    // Push and pop together while full: accepted, lands at the tail
    tdata = 32'h0ABCD7F3; ready = 1'b1; m_tready = 1'b1;
    exp_q.push_back(32'h0ABCD7F3);
    @(posedge clk); #1;
    ready = 1'b0; m_tready = 1'b0;
    check("fullpp_count", 32'(count), 32'd16);
    check("fullpp_drop", 32'(drop_cnt), 32'd2);
    check("fullpp_head", m_tdata, mk_rec(1));
    @(posedge clk); #1;
    drain();

    // clear coincident with a drop, then clear alone
    do_reset();
    fill16();
    push(mk_rec(40), 1);
    check("pre_clear_drop", 32'(drop_cnt), 32'd1);
    tdata = mk_rec(41); ready = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; clear = 1'b0;
    check("clr_drop_ovf", 32'(overflow), 32'd1);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd1);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_cnt", 32'(drop_cnt), 32'd0);
    check("clr_count", 32'(count), 32'd16);
    check("clr_head", m_tdata, mk_rec(0));
    drain();

    // Asynchronous reset mid-cycle at occupancy 5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(mk_rec(60 + i), 1);
      exp_q.push_back(mk_rec(60 + i));
    end
    check("pre_arst_count", 32'(count), 32'd5);
    #2;
    rst = 1'b1;
    tdata = 32'h0CAFE5A3; ready = 1'b1;
    #1;
    check("arst_tvalid", 32'(m_tvalid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 ready = 1'b0;
    exp_q.push_back(32'h0CAFE5A3);
    check("post_arst_count", 32'(count), 32'd1);
    check("post_arst_tdata", m_tdata, 32'h0CAFE5A3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
